// File: rtl/dht22_emulator.sv
// dht22_emulator: responder side of a DHT22/AM2302 single-wire bus.
// Watches the open-drain line for a host start pulse, then answers with the
// sensor handshake and a 40-bit humidity/temperature/checksum frame.
// One clock tick is one microsecond; all phase lengths are in ticks.
module dht22_emulator #(
  parameter int START_MIN = 500,
  parameter int T_WAIT    = 30,
  parameter int T_RESP    = 80,
  parameter int T_BITLOW  = 50,
  parameter int T_ZERO    = 26,
  parameter int T_ONE     = 70,
  parameter int T_GUARD   = 3
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         sda,
  input  logic        enable,
  input  logic [15:0] humidity,
  input  logic [15:0] temperature,
  input  logic        err_inject,
  output logic        busy,
  output logic        frame_done,
  output logic        abort,
  output logic [39:0] last_frame
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RESP_L, S_RESP_H, S_BIT_L, S_BIT_H, S_END_L
  } state_t;

  // A phase lasting n ticks ends on the tick where the counter reads n-1.
  localparam logic [9:0] CNT_MAX     = 10'h3FF;
  localparam logic [9:0] START_MIN_C = 10'(START_MIN);
  localparam logic [9:0] WAIT_LAST   = 10'(T_WAIT - 1);
  localparam logic [9:0] RESP_LAST   = 10'(T_RESP - 1);
  localparam logic [9:0] BITLOW_LAST = 10'(T_BITLOW - 1);
  localparam logic [9:0] ZERO_LAST   = 10'(T_ZERO - 1);
  localparam logic [9:0] ONE_LAST    = 10'(T_ONE - 1);
  localparam logic [9:0] GUARD_C     = 10'(T_GUARD);

  // Mod-256 sum of the four data bytes; carries out of bit 7 are dropped,
  // which matches a wider sum truncated to its low byte.
  function automatic logic [7:0] checksum(input logic [15:0] hum,
                                          input logic [15:0] temp,
                                          input logic        inj);
    logic [7:0] sum;
    sum = hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
    return sum ^ {8{inj}};
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  logic [39:0] shreg_q, shreg_d;
  logic [39:0] last_frame_q, last_frame_d;
  logic        frame_done_q, frame_done_d;
  logic        abort_q, abort_d;
  logic        sync1_q, sda_s_q, sda_prev_q;
  logic        drive_low;
  logic        released;
  logic        sda_rise;
  logic [9:0]  cnt_inc;
  logic [39:0] snap;

  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;
  assign sda_rise = sda_s_q & ~sda_prev_q;
  assign snap     = {humidity, temperature, checksum(humidity, temperature, err_inject)};

  // State register, bus synchronizer and all sequential state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      last_frame_q <= '0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      sync1_q      <= 1'b1;
      sda_s_q      <= 1'b1;
      sda_prev_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      last_frame_q <= last_frame_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
      sync1_q      <= sda;
      sda_s_q      <= sync1_q;
      sda_prev_q   <= sda_s_q;
    end
  end

  // Next-state logic: phase sequencing, start detection and collision abort.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_inc;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    last_frame_d = last_frame_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;
    released     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Measure the current low run; a high line restarts the measurement.
        cnt_d = sda_s_q ? 10'd0 : cnt_inc;
        if (sda_rise && enable && (cnt_q >= START_MIN_C)) begin
          state_d      = S_WAIT;
          cnt_d        = '0;
          shreg_d      = snap;
          last_frame_d = snap;
        end
      end
      S_WAIT: begin
        released = 1'b1;
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RESP_L;
          cnt_d   = '0;
        end
      end
      S_RESP_L: begin
        if (cnt_q == RESP_LAST) begin
          state_d = S_RESP_H;
          cnt_d   = '0;
        end
      end
      S_RESP_H: begin
        released = 1'b1;
        if (cnt_q == RESP_LAST) begin
          state_d   = S_BIT_L;
          cnt_d     = '0;
          bit_idx_d = 6'd39;
        end
      end
      S_BIT_L: begin
        if (cnt_q == BITLOW_LAST) begin
          state_d = S_BIT_H;
          cnt_d   = '0;
        end
      end
      S_BIT_H: begin
        released = 1'b1;
        if (cnt_q == (shreg_q[39] ? ONE_LAST : ZERO_LAST)) begin
          shreg_d = {shreg_q[38:0], 1'b0};
          cnt_d   = '0;
          if (bit_idx_q == 6'd0) begin
            state_d = S_END_L;
          end else begin
            bit_idx_d = bit_idx_q - 6'd1;
            state_d   = S_BIT_L;
          end
        end
      end
      S_END_L: begin
        if (cnt_q == BITLOW_LAST) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Someone else holding the line low while we have it released, once the
    // synchronizer lag and rise time are past, means the frame is lost.
    if (released && !sda_s_q && (cnt_q >= GUARD_C)) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      abort_d      = 1'b1;
      frame_done_d = 1'b0;
    end
  end

  // Output decode: which phases pull the line low, and the busy flag.
  always_comb begin
    drive_low = (state_q == S_RESP_L) || (state_q == S_BIT_L) || (state_q == S_END_L);
    busy      = (state_q != S_IDLE);
  end

  // Open-drain: only ever pull low, and let go the instant reset asserts.
  assign sda        = (reset && drive_low) ? 1'b0 : 1'bz;
  assign frame_done = frame_done_q;
  assign abort      = abort_q;
  assign last_frame = last_frame_q;

endmodule

// File: tb/tb_dht22_emulator.sv
// Bench for dht22_emulator: host-side stimulus on the shared line, a
// scoreboard of expected frames, and a monitor that decodes the wire.
module tb_dht22_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        err_inject;
  logic        busy;
  logic        frame_done;
  logic        abort;
  logic [39:0] last_frame;
  logic        host_low;
  wire         sda;

  pullup (sda);
  assign sda = host_low ? 1'b0 : 1'bz;

  dht22_emulator dut (
    .clk         (clk),
    .reset       (reset),
    .sda         (sda),
    .enable      (enable),
    .humidity    (humidity),
    .temperature (temperature),
    .err_inject  (err_inject),
    .busy        (busy),
    .frame_done  (frame_done),
    .abort       (abort),
    .last_frame  (last_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_abort;
    logic [39:0] frame;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // monitor state
  int          runs[$];
  int          hi_run = 0;
  int          busy_cyc = 0;
  bit          busy_prev = 1'b0;
  exp_t        mon_e;
  logic [39:0] mon_dec;
  int          mon_n1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: frame = {hum, temp, byte-sum mod 256, inverted on error injection}
  function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t,
                                              input logic e);
    int s;
    logic [7:0] c;
    s = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
    c = 8'(s % 256);
    if (e) c = ~c;
    return {h, t, c};
  endfunction

  // Monitor: measure high runs while busy, decode bits, check on each pulse.
  always @(negedge clk) begin
    if (!reset) begin
      runs.delete();
      hi_run    = 0;
      busy_cyc  = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        runs.delete();
        hi_run   = 0;
        busy_cyc = 0;
      end
      if (busy) begin
        busy_cyc++;
        if (sda) hi_run++;
        else if (hi_run != 0) begin
          runs.push_back(hi_run);
          hi_run = 0;
        end
      end
      busy_prev = busy;
      if (frame_done) begin
        if (exp_q.size() == 0) check("unexpected_frame_done", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("done_kind", 64'(mon_e.is_abort), 64'd0);
          check("high_run_count", 64'(runs.size()), 64'd42);
          mon_dec = '0;
          for (int i = 2; i < runs.size(); i++) mon_dec = {mon_dec[38:0], (runs[i] >= 30)};
          check("wire_frame", 64'(mon_dec), 64'(mon_e.frame));
          check("last_frame", 64'(last_frame), 64'(mon_e.frame));
          mon_n1 = $countones(mon_e.frame);
          check("busy_ticks", 64'(busy_cyc), 64'(2240 + 26 * (40 - mon_n1) + 70 * mon_n1));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
      if (abort) begin
        if (exp_q.size() == 0) check("unexpected_abort", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("abort_kind", 64'(mon_e.is_abort), 64'd1);
          check("abort_last_frame", 64'(last_frame), 64'(mon_e.frame));
          check("busy_at_abort", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic host_start(input int low_ticks);
    @(negedge clk);
    host_low = 1'b1;
    repeat (low_ticks) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic expect_frame(input logic [39:0] f, input bit ab);
    exp_t e;
    e.is_abort = ab;
    e.frame    = f;
    exp_q.push_back(e);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_seen"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 64'(n < 6000), 64'd1);
  endtask

  task automatic quiet(input string name, input int low_ticks);
    int hits;
    hits = 0;
    host_start(low_ticks);
    repeat (200) begin
      @(negedge clk);
      if (busy) hits++;
    end
    check(name, 64'(hits), 64'd0);
  endtask

  task automatic randomize_data();
    humidity    = 16'($urandom);
    temperature = 16'($urandom);
    err_inject  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int n;
    reset = 1'b0; enable = 1'b1; humidity = '0; temperature = '0;
    err_inject = 1'b0; host_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_last_frame", 64'(last_frame), 64'd0);
    check("rst_sda", 64'(sda), 64'd1);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_sda", 64'(sda), 64'd1);

    // normal frame
    humidity = 16'h028C; temperature = 16'h00DF; err_inject = 1'b0;
    expect_frame(40'h028C00DF6D, 1'b0);
    host_start(1000);
    wait_busy("normal");
    wait_idle("normal");

    // checksum corruption; inputs changed after snapshot must not matter
    err_inject = 1'b1;
    expect_frame(40'h028C00DF92, 1'b0);
    host_start(1000);
    wait_busy("err_inject");
    err_inject = 1'b0; humidity = 16'hFFFF;
    wait_idle("err_inject");

    // rejected starts
    quiet("short_start", 100);
    quiet("start_499", 499);
    enable = 1'b0;
    quiet("enable_off", 1000);
    enable = 1'b1;

    // enable dropped mid-frame
    randomize_data();
    expect_frame(model_frame(humidity, temperature, err_inject), 1'b0);
    host_start(700);
    wait_busy("enable_drop");
    repeat (300) @(negedge clk);
    enable = 1'b0;
    wait_idle("enable_drop");
    enable = 1'b1;

    // collision 10 ticks into the response-high phase
    randomize_data();
    expect_frame(model_frame(humidity, temperature, err_inject), 1'b1);
    host_start(800);
    wait_busy("collision");
    repeat (120) @(negedge clk);
    host_low = 1'b1;
    repeat (10) @(negedge clk);
    host_low = 1'b0;
    repeat (5) @(negedge clk);
    check("coll_popped", 64'(exp_q.size()), 64'd0);
    check("coll_busy", 64'(busy), 64'd0);
    check("coll_sda_released", 64'(sda), 64'd1);
    randomize_data();
    expect_frame(model_frame(humidity, temperature, err_inject), 1'b0);
    host_start(600);
    wait_busy("after_collision");
    wait_idle("after_collision");

    // asynchronous reset during bit 20
    randomize_data();
    host_start(600);
    wait_busy("reset_frame");
    n = 0;
    while (runs.size() < 21 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit20", 64'(runs.size() >= 21), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_sda", 64'(sda), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_frame_done", 64'(frame_done), 64'd0);
    check("mid_rst_abort", 64'(abort), 64'd0);
    check("mid_rst_last_frame", 64'(last_frame), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    randomize_data();
    expect_frame(model_frame(humidity, temperature, err_inject), 1'b0);
    host_start(600);
    wait_busy("after_reset");
    wait_idle("after_reset");

    // random frames, first at the exact minimum start length
    for (int k = 0; k < 3; k++) begin
      randomize_data();
      expect_frame(model_frame(humidity, temperature, err_inject), 1'b0);
      host_start((k == 0) ? 500 : int'($urandom_range(500, 900)));
      wait_busy("random");
      repeat (200) @(negedge clk);
      randomize_data();
      wait_idle("random");
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
